// File: rtl/multiplier_datapath.sv
// Register/adder datapath of the signed shift-add multiplier: X:A:B registers, WIDTH+1-bit adder.
// Optional shift counter and Done flag are built when MULT_DP_SHIFT_COUNT_EN is defined.
module multiplier_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr_Ld,
    input  logic             Add,
    input  logic             Sub,
    input  logic             Shift,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             M,
    output logic             Done
);

    localparam int AW = WIDTH + 1;

    logic signed [WIDTH-1:0] a_q, a_d;
    logic        [WIDTH-1:0] b_q, b_d;
    logic                    x_q, x_d;
    logic signed [AW-1:0]    sum_p0;

    function automatic logic signed [AW-1:0] sext(input logic signed [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

    // Overflow beyond AW bits wraps and is discarded; sign-extended operands never need it.
    function automatic logic signed [AW-1:0] addsub(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] s,
                                                     input logic                    sub);
        logic signed [AW-1:0] op;
        op = sub ? ~sext(s) : sext(s);
        return sext(a) + op + {{(AW-1){1'b0}}, sub};
    endfunction

    // Sub outranks Add, so Sub alone selects the adder mode.
    assign sum_p0 = addsub(a_q, $signed(S), Sub);

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        x_d = x_q;
        if (Clr_Ld) begin
            a_d = '0;
            x_d = 1'b0;
            b_d = S;
        end else if (Sub || Add) begin
            if (b_q[0]) begin
                {x_d, a_d} = sum_p0;
            end
        end else if (Shift) begin
            a_d = {x_q, a_q[WIDTH-1:1]};
            b_d = {a_q[0], b_q[WIDTH-1:1]};
        end
    end

    // Registered stage: every output comes straight from these flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q <= '0;
            b_q <= '0;
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign M    = b_q[0];

`ifdef MULT_DP_SHIFT_COUNT_EN
    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // Only a Shift that actually executes counts; the counter saturates at WIDTH.
    always_comb begin
        cnt_d = cnt_q;
        if (Clr_Ld) begin
            cnt_d = '0;
        end else if (!(Sub || Add) && Shift && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
        done_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign Done = done_q;
`else
    assign Done = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath: cycle model in plain arithmetic plus literal product checks.
module tb_multiplier_datapath;

    localparam int W = 8;
`ifdef MULT_DP_SHIFT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset = 1'b1, Clr_Ld = 1'b0, Add = 1'b0, Sub = 1'b0, Shift = 1'b0;
    logic [W-1:0] S = '0;
    logic [W-1:0] Aval, Bval;
    logic         X, M, Done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    multiplier_datapath #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Clr_Ld(Clr_Ld), .Add(Add), .Sub(Sub), .Shift(Shift),
        .S(S), .Aval(Aval), .Bval(Bval), .X(X), .M(M), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: {X,A,B} treated as one signed 17-bit number, adder as integer math.
    logic [W-1:0] ma, mb;
    logic         mx;
    int           mcnt;

    function automatic logic [W:0] arith(input logic [W-1:0] a, input logic [W-1:0] s, input bit sub);
        int r;
        r = sub ? (int'($signed(a)) - int'($signed(s))) : (int'($signed(a)) + int'($signed(s)));
        return r[W:0];
    endfunction

    function automatic logic [2*W:0] ashr(input logic [2*W:0] v);
        logic signed [2*W:0] t;
        t = v;
        return t >>> 1;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            ma <= '0; mb <= '0; mx <= 1'b0; mcnt <= 0;
        end else if (Clr_Ld) begin
            ma <= '0; mx <= 1'b0; mb <= S; mcnt <= 0;
        end else if (Sub || Add) begin
            if (mb[0]) {mx, ma} <= arith(ma, S, Sub);
        end else if (Shift) begin
            {mx, ma, mb} <= ashr({mx, ma, mb});
            mcnt <= (mcnt < W) ? mcnt + 1 : mcnt;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("cyc_A", Aval, ma);
            check("cyc_B", Bval, mb);
            check("cyc_X", X, mx);
            check("cyc_M", M, mb[0]);
            check("cyc_Done", Done, CNT_EN && (mcnt == W));
        end
    end

    task automatic cmd(input logic r, input logic cl, input logic ad, input logic sb,
                       input logic sh, input logic [W-1:0] s);
        Reset = r; Clr_Ld = cl; Add = ad; Sub = sb; Shift = sh; S = s;
        @(posedge Clk);
        #1;
        Reset = 1'b0; Clr_Ld = 1'b0; Add = 1'b0; Sub = 1'b0; Shift = 1'b0;
    endtask

    task automatic mult(input logic [W-1:0] mcand, input logic [W-1:0] mplier);
        cmd(0, 1, 0, 0, 0, mplier);
        for (int i = 0; i < W - 1; i++) begin
            cmd(0, 0, 1, 0, 0, mcand);
            cmd(0, 0, 0, 0, 1, mcand);
        end
        cmd(0, 0, 0, 1, 0, mcand);
        cmd(0, 0, 0, 0, 1, mcand);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [31:0]  p;
        int           ip;
        logic [31:0]  r;

        cmd(1, 0, 0, 0, 0, 8'h00);
        chk_en = 1'b1;
        check("rst_A", Aval, 8'h00);
        check("rst_Done", Done, 1'b0);

        // Reset from a loaded A=B=0xFF state
        cmd(0, 1, 0, 0, 0, 8'hFF);
        cmd(0, 0, 0, 1, 0, 8'h01);
        check("t1_preA", Aval, 8'hFF);
        check("t1_preB", Bval, 8'hFF);
        cmd(1, 0, 0, 0, 0, 8'h00);
        check("t1_A", Aval, 8'h00);
        check("t1_B", Bval, 8'h00);
        check("t1_X", X, 1'b0);
        check("t1_M", M, 1'b0);
        check("t1_Done", Done, 1'b0);

        mult(8'h07, 8'h3B);
        check("t2_A", Aval, 8'h01);
        check("t2_B", Bval, 8'h9D);
        check("t2_X", X, 1'b0);
        check("t2_Done", Done, CNT_EN);

        mult(8'h3B, 8'hF9);
        check("t3_A", Aval, 8'hFE);
        check("t3_B", Bval, 8'h63);
        check("t3_X", X, 1'b1);

        cmd(0, 1, 0, 0, 0, 8'h02);
        cmd(0, 0, 1, 0, 0, 8'h7F);
        check("t4_A", Aval, 8'h00);
        check("t4_X", X, 1'b0);
        check("t4_B", Bval, 8'h02);

        cmd(0, 1, 0, 0, 1, 8'h81);
        check("t5_B", Bval, 8'h81);
        check("t5_A", Aval, 8'h00);
        cmd(0, 0, 1, 1, 0, 8'h01);
        check("t5_A_sub", Aval, 8'hFF);
        check("t5_X_sub", X, 1'b1);
        for (int i = 0; i < W - 1; i++) cmd(0, 0, 0, 0, 1, 8'h00);
        check("t5_cnt_not_done", Done, 1'b0);
        cmd(0, 0, 0, 0, 1, 8'h00);
        check("t5_cnt_done", Done, CNT_EN);

        // Reset after four shifts of the 59*7 sequence
        cmd(0, 1, 0, 0, 0, 8'h3B);
        for (int i = 0; i < 4; i++) begin
            cmd(0, 0, 1, 0, 0, 8'h07);
            cmd(0, 0, 0, 0, 1, 8'h07);
        end
        cmd(1, 0, 0, 0, 0, 8'h07);
        check("t6_A", Aval, 8'h00);
        check("t6_B", Bval, 8'h00);
        check("t6_X", X, 1'b0);
        check("t6_Done", Done, 1'b0);
        cmd(0, 1, 0, 0, 0, 8'h3B);
        for (int i = 0; i < W - 1; i++) begin
            cmd(0, 0, 0, 0, 1, 8'h00);
            check("t6_Done_early", Done, 1'b0);
        end
        cmd(0, 0, 0, 0, 1, 8'h00);
        check("t6_Done_final", Done, CNT_EN);

        // Random full multiplies against plain integer product
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (k == 0) begin ra = 8'h80; rb = 8'h80; end
            if (k == 1) begin ra = 8'h7F; rb = 8'h80; end
            mult(ra, rb);
            ip = int'($signed(ra)) * int'($signed(rb));
            p  = ip;
            check("rnd_prod", {16'h0, Aval, Bval}, {16'h0, p[15:0]});
            check("rnd_sign", X, ip < 0);
        end

        // Random command stream checked cycle by cycle by the model
        for (int k = 0; k < 800; k++) begin
            r = $urandom;
            cmd(r[7:0] < 8'd4, r[15:8] < 8'd20, r[16], r[17] & r[18], r[19],
                8'($urandom_range(0, 255)));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
